// File: rtl/raster_qe_arb_pkg.sv
// Shared definitions for the raster QE arbiter: FSM state encodings and tag-width helper.
package raster_qe_arb_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // A single requester still needs a 1-bit tag so ports never collapse to zero width.
  function automatic int req_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_qe_arb_rr_arbiter.sv
// Generic round-robin arbiter: picks the first request at or after the pointer,
// and moves the pointer past the winner when advance is asserted.
module raster_qe_arb_rr_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int REQ_BITS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                advance,
  output logic [REQ_BITS-1:0] grant_index,
  output logic [NUM_REQS-1:0] grant_onehot,
  output logic                grant_valid
);

  logic [REQ_BITS-1:0] ptr_q;
  logic [REQ_BITS-1:0] ptr_next;

  always_comb begin
    int j;
    j            = 0;
    grant_valid  = 1'b0;
    grant_index  = ptr_q;
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      j = (int'(ptr_q) + i) % NUM_REQS;
      if (!grant_valid && requests[j]) begin
        grant_valid     = 1'b1;
        grant_index     = REQ_BITS'(j);
        grant_onehot[j] = 1'b1;
      end
    end
  end

  always_comb begin
    int n;
    n        = (int'(grant_index) + 1) % NUM_REQS;
    ptr_next = REQ_BITS'(n);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr_next;
    end
  end

endmodule

// File: rtl/raster_qe_arb.sv
// Shares one quad evaluator among NUM_REQS block evaluators, locking the grant per primitive burst.
//   state     | meaning
//   ST_IDLE   | round-robin pick among valid requesters each cycle
//   ST_LOCKED | mid-burst; grant held on lock_tag until its last batch issues
module raster_qe_arb
  import raster_qe_arb_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int NUM_QUADS = 4,
  parameter int REQ_BITS  = req_bits(NUM_REQS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQS-1:0]  req_valid,
  input  logic [NUM_REQS-1:0]  req_last,
  output logic [NUM_REQS-1:0]  req_ready,
  output logic [REQ_BITS-1:0]  grant_sel,
  output logic                 qe_valid_in,
  output logic                 qe_enable,
  input  logic                 qe_valid_out,
  input  logic [NUM_QUADS-1:0] qe_overlap_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REQ_BITS-1:0]  out_reqid,
  output logic [NUM_REQS-1:0]  req_done,
  output logic [31:0]          perf_batches,
  output logic [31:0]          perf_culled,
  output logic [31:0]          perf_stalls
);

  logic [0:0]          state_q;
  logic [REQ_BITS-1:0] lock_tag_q;
  logic [REQ_BITS-1:0] sh_tag_q;
  logic                sh_last_q;
  logic [NUM_REQS-1:0] lock_onehot;
  logic [NUM_REQS-1:0] arb_req;
  logic [NUM_REQS-1:0] gnt_onehot;
  logic                gnt_valid;
  logic                handshake;
  logic                last_sel;
  logic                retire;
  logic [NUM_REQS-1:0] done_next;

  always_comb begin
    lock_onehot = '0;
    for (int r = 0; r < NUM_REQS; r++) begin
      lock_onehot[r] = (lock_tag_q == REQ_BITS'(r));
    end
  end

  // While locked the arbiter only ever sees the owner, so it cannot hand the QE away.
  assign arb_req = (state_q == ST_LOCKED) ? lock_onehot : req_valid;

  raster_qe_arb_rr_arbiter #(
    .NUM_REQS (NUM_REQS),
    .REQ_BITS (REQ_BITS)
  ) u_rr_arbiter (
    .clk          (clk),
    .reset_n      (reset_n),
    .requests     (arb_req),
    .advance      (handshake & last_sel),
    .grant_index  (grant_sel),
    .grant_onehot (gnt_onehot),
    .grant_valid  (gnt_valid)
  );

  assign out_valid   = qe_valid_out & (|qe_overlap_out);
  assign qe_enable   = ~out_valid | out_ready;
  assign req_ready   = (qe_enable & gnt_valid) ? gnt_onehot : '0;
  assign handshake   = |(req_valid & req_ready);
  assign qe_valid_in = handshake;
  assign last_sel    = |(req_last & gnt_onehot);
  assign retire      = qe_valid_out & qe_enable;
  assign out_reqid   = sh_tag_q;

  always_comb begin
    done_next = '0;
    for (int r = 0; r < NUM_REQS; r++) begin
      done_next[r] = retire & sh_last_q & (sh_tag_q == REQ_BITS'(r));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      lock_tag_q <= '0;
    end else if (handshake) begin
      if (last_sel) begin
        state_q <= ST_IDLE;
      end else begin
        state_q    <= ST_LOCKED;
        lock_tag_q <= grant_sel;
      end
    end
  end

  // Shadow follows the QE's one-cycle latency so the tag lines up with qe_valid_out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_tag_q  <= '0;
      sh_last_q <= 1'b0;
    end else if (qe_enable) begin
      sh_tag_q  <= grant_sel;
      sh_last_q <= handshake & last_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_done     <= '0;
      perf_batches <= '0;
      perf_culled  <= '0;
      perf_stalls  <= '0;
    end else begin
      req_done <= done_next;
      if (handshake)                      perf_batches <= perf_batches + 32'd1;
      if (retire && !(|qe_overlap_out))   perf_culled  <= perf_culled + 32'd1;
      if (out_valid && !out_ready)        perf_stalls  <= perf_stalls + 32'd1;
    end
  end

endmodule

// File: tb/tb_raster_qe_arb.sv
// Directed bench for raster_qe_arb with a one-cycle behavioural QE pipe.
module tb_raster_qe_arb;

  localparam int NR = 4;
  localparam int NQ = 4;
  localparam int RB = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_last = '0;
  logic [NR-1:0] req_ready;
  logic [RB-1:0] grant_sel;
  logic          qe_valid_in;
  logic          qe_enable;
  logic          qe_valid_out;
  logic [NQ-1:0] qe_overlap_out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [RB-1:0] out_reqid;
  logic [NR-1:0] req_done;
  logic [31:0]   perf_batches;
  logic [31:0]   perf_culled;
  logic [31:0]   perf_stalls;
  logic [NQ-1:0] ovl_drive = '0;

  int n_vec = 0;
  int n_err = 0;

  raster_qe_arb #(.NUM_REQS(NR), .NUM_QUADS(NQ), .REQ_BITS(RB)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .grant_sel      (grant_sel),
    .qe_valid_in    (qe_valid_in),
    .qe_enable      (qe_enable),
    .qe_valid_out   (qe_valid_out),
    .qe_overlap_out (qe_overlap_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_reqid      (out_reqid),
    .req_done       (req_done),
    .perf_batches   (perf_batches),
    .perf_culled    (perf_culled),
    .perf_stalls    (perf_stalls)
  );

  always #5 clk = ~clk;

  // Behavioural QE: one-cycle pipe, frozen when enable is low, flushed by reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qe_valid_out   <= 1'b0;
      qe_overlap_out <= '0;
    end else if (qe_enable) begin
      qe_valid_out   <= qe_valid_in;
      qe_overlap_out <= ovl_drive;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    out_ready = 1'b1;
    ovl_drive = '0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = '0;
    #12;
    n_vec++; if (grant_sel !== 2'd0) begin n_err++; $display("FAIL rst_grant got %0d want 0", grant_sel); end
    n_vec++; if (qe_enable !== 1'b1) begin n_err++; $display("FAIL rst_qe_enable got %0b want 1", qe_enable); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready got %b want 0000", req_ready); end
    n_vec++; if (qe_valid_in !== 1'b0) begin n_err++; $display("FAIL rst_qe_valid_in got %0b want 0", qe_valid_in); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_vec++; if (out_reqid !== 2'd0) begin n_err++; $display("FAIL rst_out_reqid got %0d want 0", out_reqid); end
    n_vec++; if (req_done !== 4'b0000) begin n_err++; $display("FAIL rst_done got %b want 0000", req_done); end
    n_vec++; if ({perf_batches, perf_culled, perf_stalls} !== 96'd0) begin n_err++; $display("FAIL rst_perf got %0d/%0d/%0d want 0/0/0", perf_batches, perf_culled, perf_stalls); end
  endtask

  task automatic test_single_burst();
    do_reset();
    ovl_drive = 4'b0001; req_valid = 4'b0001; req_last = 4'b0000; #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL sb_ready got %b want 0001", req_ready); end
    n_vec++; if (qe_valid_in !== 1'b1) begin n_err++; $display("FAIL sb_qe_valid_in got %0b want 1", qe_valid_in); end
    cyc(); #1;
    n_vec++; if ({out_valid, out_reqid} !== 3'b1_00) begin n_err++; $display("FAIL sb_out1 got %0b/%0d want 1/0", out_valid, out_reqid); end
    cyc(); req_last = 4'b0001; #1;
    n_vec++; if ({out_valid, out_reqid} !== 3'b1_00) begin n_err++; $display("FAIL sb_out2 got %0b/%0d want 1/0", out_valid, out_reqid); end
    cyc(); req_valid = '0; req_last = '0; #1;
    n_vec++; if ({out_valid, out_reqid} !== 3'b1_00) begin n_err++; $display("FAIL sb_out3 got %0b/%0d want 1/0", out_valid, out_reqid); end
    n_vec++; if (req_done !== 4'b0000) begin n_err++; $display("FAIL sb_done_early got %b want 0000", req_done); end
    cyc(); #1;
    n_vec++; if (req_done !== 4'b0001) begin n_err++; $display("FAIL sb_done got %b want 0001", req_done); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sb_out_idle got %0b want 0", out_valid); end
    n_vec++; if (perf_batches !== 32'd3) begin n_err++; $display("FAIL sb_batches got %0d want 3", perf_batches); end
    cyc(); #1;
    n_vec++; if (req_done !== 4'b0000) begin n_err++; $display("FAIL sb_done_once got %b want 0000", req_done); end
  endtask

  task automatic test_rotation();
    logic [RB-1:0] seq [5];
    logic [NR-1:0] exp_done;
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    ovl_drive = 4'b0001; req_last = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) cyc();
      req_valid = (k < 5) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 5) begin
        n_vec++; if (grant_sel !== seq[k]) begin n_err++; $display("FAIL rot_grant[%0d] got %0d want %0d", k, grant_sel, seq[k]); end
        n_vec++; if (req_ready !== (4'b0001 << seq[k])) begin n_err++; $display("FAIL rot_ready[%0d] got %b want %b", k, req_ready, 4'b0001 << seq[k]); end
      end
      exp_done = (k >= 2) ? (4'b0001 << seq[k-2]) : 4'b0000;
      n_vec++; if (req_done !== exp_done) begin n_err++; $display("FAIL rot_done[%0d] got %b want %b", k, req_done, exp_done); end
    end
    n_vec++; if (perf_batches !== 32'd5) begin n_err++; $display("FAIL rot_batches got %0d want 5", perf_batches); end
  endtask

  task automatic test_lock();
    do_reset();
    ovl_drive = 4'b0001; req_valid = 4'b0100; req_last = 4'b0000; #1;
    n_vec++; if (grant_sel !== 2'd2) begin n_err++; $display("FAIL lk_grant0 got %0d want 2", grant_sel); end
    cyc(); req_valid = 4'b0111; #1;
    n_vec++; if ({grant_sel, req_ready} !== {2'd2, 4'b0100}) begin n_err++; $display("FAIL lk_hold1 got %0d/%b want 2/0100", grant_sel, req_ready); end
    cyc(); req_valid = 4'b0011; #1;
    n_vec++; if ({grant_sel, req_ready, qe_valid_in} !== {2'd2, 4'b0100, 1'b0}) begin n_err++; $display("FAIL lk_hold2 got %0d/%b/%0b want 2/0100/0", grant_sel, req_ready, qe_valid_in); end
    n_vec++; if ({out_valid, out_reqid} !== 3'b1_10) begin n_err++; $display("FAIL lk_reqid got %0b/%0d want 1/2", out_valid, out_reqid); end
    cyc(); req_valid = 4'b0111; req_last = 4'b0100; #1;
    n_vec++; if (grant_sel !== 2'd2) begin n_err++; $display("FAIL lk_hold3 got %0d want 2", grant_sel); end
    cyc(); req_valid = 4'b0011; req_last = 4'b0000; #1;
    n_vec++; if ({grant_sel, req_ready} !== {2'd0, 4'b0001}) begin n_err++; $display("FAIL lk_next got %0d/%b want 0/0001", grant_sel, req_ready); end
    cyc(); req_valid = 4'b0000; #1;
    n_vec++; if (req_done !== 4'b0100) begin n_err++; $display("FAIL lk_done got %b want 0100", req_done); end
  endtask

  task automatic test_cull();
    do_reset();
    ovl_drive = 4'b0000; req_valid = 4'b0010; req_last = 4'b0010; #1;
    cyc(); req_valid = '0; req_last = '0; #1;
    n_vec++; if ({qe_valid_out, out_valid, qe_enable} !== 3'b101) begin n_err++; $display("FAIL cl_out got v%0b o%0b e%0b want v1 o0 e1", qe_valid_out, out_valid, qe_enable); end
    cyc(); #1;
    n_vec++; if (perf_culled !== 32'd1) begin n_err++; $display("FAIL cl_culled got %0d want 1", perf_culled); end
    n_vec++; if (req_done !== 4'b0010) begin n_err++; $display("FAIL cl_done got %b want 0010", req_done); end
    n_vec++; if (perf_batches !== 32'd1) begin n_err++; $display("FAIL cl_batches got %0d want 1", perf_batches); end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0; ovl_drive = 4'b0101; req_valid = 4'b0001; req_last = 4'b0000; #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL st_ready0 got %b want 0001", req_ready); end
    for (int k = 1; k <= 5; k++) begin
      cyc(); req_last = 4'b0001; #1;
      n_vec++; if ({qe_enable, req_ready, qe_valid_in} !== {1'b0, 4'b0000, 1'b0}) begin n_err++; $display("FAIL st_frozen[%0d] got e%0b r%b i%0b want e0 r0000 i0", k, qe_enable, req_ready, qe_valid_in); end
      n_vec++; if ({out_valid, out_reqid} !== 3'b1_00) begin n_err++; $display("FAIL st_hold[%0d] got %0b/%0d want 1/0", k, out_valid, out_reqid); end
      n_vec++; if (perf_stalls !== 32'(k - 1)) begin n_err++; $display("FAIL st_count[%0d] got %0d want %0d", k, perf_stalls, k - 1); end
    end
    cyc(); out_ready = 1'b1; ovl_drive = 4'b0011; #1;
    n_vec++; if ({qe_enable, req_ready, out_valid} !== {1'b1, 4'b0001, 1'b1}) begin n_err++; $display("FAIL st_resume got e%0b r%b o%0b want e1 r0001 o1", qe_enable, req_ready, out_valid); end
    n_vec++; if (perf_stalls !== 32'd5) begin n_err++; $display("FAIL st_stalls got %0d want 5", perf_stalls); end
    cyc(); req_valid = '0; req_last = '0; #1;
    n_vec++; if ({out_valid, out_reqid, perf_batches} !== {1'b1, 2'd0, 32'd2}) begin n_err++; $display("FAIL st_second got %0b/%0d/%0d want 1/0/2", out_valid, out_reqid, perf_batches); end
    cyc(); #1;
    n_vec++; if ({out_valid, req_done} !== {1'b0, 4'b0001}) begin n_err++; $display("FAIL st_done got %0b/%b want 0/0001", out_valid, req_done); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    ovl_drive = 4'b1000; req_valid = 4'b0010; req_last = 4'b0000; #1;
    cyc(); #1;
    cyc(); #1;
    n_vec++; if ({out_valid, out_reqid, perf_batches} !== {1'b1, 2'd1, 32'd2}) begin n_err++; $display("FAIL rm_pre got %0b/%0d/%0d want 1/1/2", out_valid, out_reqid, perf_batches); end
    #1; reset_n = 1'b0; req_valid = '0; #1;
    n_vec++; if ({out_valid, out_reqid, grant_sel, req_ready} !== {1'b0, 2'd0, 2'd0, 4'b0000}) begin n_err++; $display("FAIL rm_async got o%0b t%0d g%0d r%b want all 0", out_valid, out_reqid, grant_sel, req_ready); end
    n_vec++; if ({perf_batches, perf_culled, perf_stalls} !== 96'd0) begin n_err++; $display("FAIL rm_perf got %0d/%0d/%0d want 0/0/0", perf_batches, perf_culled, perf_stalls); end
    cyc(); cyc(); reset_n = 1'b1; #1;
    cyc(); req_valid = 4'b0011; #1;
    n_vec++; if ({grant_sel, req_ready} !== {2'd0, 4'b0001}) begin n_err++; $display("FAIL rm_idle got %0d/%b want 0/0001", grant_sel, req_ready); end
    n_vec++; if (req_done !== 4'b0000) begin n_err++; $display("FAIL rm_done1 got %b want 0000", req_done); end
    req_valid = '0;
    cyc(); #1;
    n_vec++; if (req_done !== 4'b0000) begin n_err++; $display("FAIL rm_done2 got %b want 0000", req_done); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_rotation();
    test_lock();
    test_cull();
    test_stall();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
